// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the five-stage Y86-64 pipeline: stall/bubble generation,
// exception drain/halt sequencing and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int          CNT_W    = 32,
    parameter logic [2:0]  STAT_AOK = 3'd1,
    parameter logic [2:0]  STAT_HLT = 3'd2,
    parameter logic [2:0]  STAT_ADR = 3'd3,
    parameter logic [2:0]  STAT_INS = 3'd4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_Ins_Code,
    input  logic [3:0]       E_Ins_Code,
    input  logic [3:0]       M_Ins_Code,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [2:0]       halt_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_halt_stat;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_lu, w_rt, w_mp, w_m_exc, w_w_exc, w_active;

    function automatic logic f_exc(input logic [2:0] s);
        case (s)
            STAT_AOK:                     f_exc = 1'b0;
            STAT_HLT, STAT_ADR, STAT_INS: f_exc = 1'b1;
            default:                      f_exc = 1'b0;
        endcase
    endfunction

    assign w_lu = (E_Ins_Code == I_MRMOVQ || E_Ins_Code == I_POPQ) && E_dstM != R_NONE &&
                  (E_dstM == d_srcA || E_dstM == d_srcB);
    assign w_rt = (D_Ins_Code == I_RET) || (E_Ins_Code == I_RET) || (M_Ins_Code == I_RET);
    assign w_mp = (E_Ins_Code == I_JXX) && !e_Cnd;
    assign w_m_exc  = f_exc(m_stat);
    assign w_w_exc  = f_exc(W_stat);
    assign w_active = (r_state != S_HALTED);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        F_stall  = w_lu || w_rt;
        D_stall  = w_lu;
        D_bubble = w_mp || (w_rt && !w_lu);
        E_bubble = w_mp || w_lu;
        M_bubble = w_m_exc || w_w_exc;
        W_stall  = w_w_exc;
        set_cc   = (E_Ins_Code == I_OPQ) && !w_m_exc && !w_w_exc;
        halted   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_w_exc)      w_next_state = S_HALTED;
                else if (w_m_exc) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_w_exc) w_next_state = S_HALTED;
            end
            S_HALTED: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                D_bubble = 1'b0;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
                set_cc   = 1'b0;
                halted   = 1'b1;
            end
            default: w_next_state = S_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_halt_stat <= 3'd0;
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_active && w_next_state == S_HALTED)
                r_halt_stat <= W_stat;
            // Counters stick at all-ones instead of wrapping.
            if (w_active && r_cycle_cnt != '1)
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_active && w_lu && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_active && w_mp && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign halt_stat = r_halt_stat;
    assign cycle_cnt = r_cycle_cnt;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline control unit for the five-stage Y86-64 pipeline.
- Generates stall and bubble controls for the F, D, E, M and W pipeline registers from hazard conditions: load/use, ret, branch mispredict and exception.
- Sequences the pipeline through run, drain and halt on an exceptional status.
- Keeps saturating performance counters and sits beside the stage registers, driving their stall/bubble inputs.

Parameters:
- CNT_W, 32, width of each performance counter.
- STAT_AOK, 3'd1, normal status code.
- STAT_HLT, 3'd2, halt status code.
- STAT_ADR, 3'd3, address-error status code.
- STAT_INS, 3'd4, illegal-instruction status code.

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- D_Ins_Code  in  4  icode in the decode register.
- E_Ins_Code  in  4  icode in the execute register.
- M_Ins_Code  in  4  icode in the memory register.
- E_dstM  in  4  dstM of the instruction in execute.
- d_srcA  in  4  srcA being decoded.
- d_srcB  in  4  srcB being decoded.
- e_Cnd  in  1  branch/cmov condition from execute.
- m_stat  in  3  status leaving the memory stage.
- W_stat  in  3  status in the writeback register.
- F_stall  out  1  hold the fetch PC register.
- D_stall  out  1  hold the decode register.
- D_bubble  out  1  inject bubble into decode.
- E_bubble  out  1  inject bubble into execute (drives E_toBubble).
- M_bubble  out  1  inject bubble into memory.
- W_stall  out  1  hold the writeback register.
- set_cc  out  1  enable condition-code update in execute.
- halted  out  1  pipeline stopped.
- halt_stat  out  3  W_stat captured at halt entry.
- cycle_cnt  out  CNT_W  cycles spent in RUN or DRAIN.
- stall_cnt  out  CNT_W  cycles with load/use stall.
- flush_cnt  out  CNT_W  cycles with mispredict flush.

Behaviour:
- Icodes: MRMOVQ=5, OPQ=6, JXX=7, RET=9, POPQ=B. RNONE=4'hF is never a hazard source.
- exc(s) is true when s is HLT, ADR or INS. Status 0 (bubble) and AOK are not exceptional.
- Combinational terms, evaluated with zero latency from current inputs:
  - lu = E_Ins_Code in {MRMOVQ, POPQ} && E_dstM != RNONE && (E_dstM == d_srcA || E_dstM == d_srcB)
  - rt = RET present in D, E or M
  - mp = E_Ins_Code == JXX && !e_Cnd
- In RUN and DRAIN:
  - F_stall = lu || rt
  - D_stall = lu
  - D_bubble = mp || (rt && !lu)
  - E_bubble = mp || lu
  - M_bubble = exc(m_stat) || exc(W_stat)
  - W_stall = exc(W_stat)
  - set_cc = E_Ins_Code == OPQ && !exc(m_stat) && !exc(W_stat)
- D_stall and D_bubble are never both 1. lu has priority over rt; when mp and lu coincide, D_bubble wins for decode.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when exc(m_stat).
  - DRAIN -> HALTED when exc(W_stat); halt_stat <= W_stat on that edge.
  - RUN with exc(W_stat) at the same edge goes straight to HALTED.
  - HALTED is held until reset.
- In HALTED:
  - F_stall = D_stall = E_bubble = M_bubble = W_stall = 1.
  - D_bubble = 0, set_cc = 0, halted = 1.
- Counters:
  - cycle_cnt increments each cycle in RUN or DRAIN.
  - stall_cnt increments when lu is true in RUN or DRAIN.
  - flush_cnt increments when mp is true in RUN or DRAIN.
  - All counters saturate at all-ones and never wrap. All freeze in HALTED.
- Reset (async, any state):
  - State goes to RUN; halt_stat = 0; all counters = 0; halted = 0.
  - Combinational outputs follow the RUN equations immediately.
  - Reset mid-drain abandons the drain.

Test Plan:
1. Reset asserted mid-cycle with state HALTED -> halted=0, counters 0, outputs follow RUN equations without waiting for clk.
2. E_Ins_Code=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt +1 per cycle; E_dstM=4'hF gives no stall.
3. D_Ins_Code=9 held for three cycles, no load/use -> F_stall=1, D_bubble=1 each cycle; combine with lu -> D_stall=1, D_bubble=0.
4. E_Ins_Code=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, flush_cnt +1; e_Cnd=1 -> no flush.
5. E_Ins_Code=6 with m_stat=3 -> set_cc=0, M_bubble=1, state DRAIN; next W_stat=3 -> W_stall=1, then halted=1, halt_stat=3, cycle_cnt frozen.
6. Force stall_cnt near all-ones (CNT_W=4 build), hold lu for 20 cycles -> counter stays at 4'hF.
